// File: rtl/wb_b3_master.sv
// Wishbone B3 burst initiator: accepts one read/write command at a time,
// runs it as a classic or incrementing/wrapping burst, reports completion.
module wb_b3_master #(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [4:0]    cmd_len_i,
  input  logic [1:0]    cmd_bte_i,
  input  logic [3:0]    cmd_sel_i,
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic [dw-1:0] wb_dat_i
);

  localparam int unsigned WDW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_END
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    sel_q, sel_d;
  logic          single_q, single_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic [dw-1:0] rd_dat_q, rd_dat_d;

  logic          stb;
  logic          beat_ok;
  logic          resp_fail;
  logic          wd_expire;
  logic          last_beat;
  logic [4:0]    len_eff;
  logic [aw-1:0] adr_inc;
  logic [aw-1:0] wrap_mask;
  logic [aw-1:0] adr_next;

  // Bus handshake qualifiers for the current cycle
  always_comb begin
    stb       = (state_q == S_BUS) && (!we_q || wr_valid_i);
    // err/rty win over a simultaneous ack: the beat is not taken
    beat_ok   = stb && wb_ack_i && !wb_err_i && !wb_rty_i;
    resp_fail = stb && (wb_err_i || wb_rty_i);
    wd_expire = stb && !wb_ack_i && !wb_err_i && !wb_rty_i &&
                (wd_q == WDW'(timeout_cycles - 1));
    last_beat = (cnt_q == 4'd0);
    len_eff   = (cmd_len_i == 5'd0) ? 5'd1 : cmd_len_i;
  end

  // Next beat address: linear, or wrapping inside a 16/32/64-byte window
  always_comb begin
    adr_inc = adr_q + aw'(4);
    case (bte_q)
      2'b01:   wrap_mask = aw'(12);
      2'b10:   wrap_mask = aw'(28);
      2'b11:   wrap_mask = aw'(60);
      default: wrap_mask = '1;
    endcase
    adr_next = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
  end

  // Command FSM: next state, command registers, beat/watchdog counters
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    bte_d      = bte_q;
    sel_d      = sel_q;
    single_d   = single_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_dat_d   = rd_dat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = S_BUS;
          we_d     = cmd_we_i;
          adr_d    = cmd_adr_i;
          single_d = (len_eff == 5'd1);
          bte_d    = (len_eff == 5'd1) ? 2'b00 : cmd_bte_i;
          sel_d    = (len_eff == 5'd1) ? cmd_sel_i : 4'hf;
          cnt_d    = 4'(len_eff - 5'd1);
          wd_d     = '0;
          err_d    = 1'b0;
        end
      end
      S_BUS: begin
        if (resp_fail || wd_expire) begin
          state_d = S_END;
          err_d   = 1'b1;
          wd_d    = '0;
        end else if (beat_ok) begin
          adr_d = adr_next;
          wd_d  = '0;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_dat_d   = wb_dat_i;
          end
          if (last_beat) state_d = S_END;
          else           cnt_d   = cnt_q - 4'd1;
        end else if (stb) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      bte_q      <= '0;
      sel_q      <= '0;
      single_q   <= 1'b0;
      cnt_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      bte_q      <= bte_d;
      sel_q      <= sel_d;
      single_q   <= single_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_dat_q   <= rd_dat_d;
    end
  end

  // Cycle type: classic for single beats, incrementing burst otherwise
  always_comb begin
    wb_cti_o = 3'b000;
    if (state_q == S_BUS && !single_q) begin
      wb_cti_o = last_beat ? 3'b111 : 3'b010;
    end
  end

  // Output mapping
  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    wb_cyc_o    = (state_q == S_BUS);
    wb_stb_o    = stb;
    wb_we_o     = we_q;
    wb_adr_o    = adr_q;
    wb_bte_o    = bte_q;
    wb_sel_o    = sel_q;
    wb_dat_o    = wr_dat_i;
    wr_ready_o  = we_q && beat_ok;
    rd_valid_o  = rd_valid_q;
    rd_dat_o    = rd_dat_q;
    done_o      = (state_q == S_END);
    err_o       = (state_q == S_END) && err_q;
  end

endmodule

// File: tb/tb_wb_b3_master.sv
// Self-checking bench for wb_b3_master: directed table, reset sequences,
// randomized commands against a transaction-level reference model.
module tb_wb_b3_master;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [4:0]  cmd_len = '0;
  logic [1:0]  cmd_bte = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wr_dat = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_dat;
  logic        rd_valid, done, err;
  logic [31:0] wb_adr, wb_dat_o;
  logic [1:0]  wb_bte;
  logic [2:0]  wb_cti;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_b3_master #(.dw(32), .aw(32), .timeout_cycles(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte), .cmd_sel_i(cmd_sel),
    .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .done_o(done), .err_o(err),
    .wb_adr_o(wb_adr), .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [4:0]  len;
    logic [1:0]  bte;
    logic [3:0]  sel;
    int          delay;        // stb cycles before the slave responds
    int          err_beat;     // beat index answered with err/rty, -1 none
    bit          rty;          // use rty instead of err on err_beat
    int          starve_after; // beat index preceded by write-data starvation
    int          starve_len;
    bit          no_resp;      // slave never answers
    bit          rnd;          // random per-beat delay and wr_valid
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte address of beat k: linear, or wrapped inside a 16/32/64-byte block
  function automatic logic [31:0] exp_adr(input logic [31:0] a, input logic [1:0] bte, input int k);
    logic [31:0] lin, span;
    lin = a + 32'(4 * k);
    if (bte == 2'b00) return lin;
    span = 32'd8 << bte;
    return (a & ~(span - 32'd1)) | (lin & (span - 32'd1));
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    int n, beat, wcnt, wd, starve_left, cur_delay, rd_seen, wr_seen;
    bit in_bus, exp_done, finishing, got_err, stb_e, ack_r, err_r, rty_r, rd_pend, fin;
    logic [31:0] rd_exp, wdat[16];
    logic [1:0] bte_e;
    n = (v.len == 0) ? 1 : int'(v.len);
    bte_e = (n == 1) ? 2'b00 : v.bte;
    for (int i = 0; i < 16; i++) wdat[i] = $urandom;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len;
    cmd_bte = v.bte; cmd_sel = v.sel;
    #1 chk({tag, ".cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    // garbage on command inputs while busy must be ignored
    cmd_valid = 1'b0; cmd_we = $urandom; cmd_adr = $urandom; cmd_len = $urandom;
    cmd_bte = $urandom; cmd_sel = $urandom;

    in_bus = 1; beat = 0; wcnt = 0; wd = 0; exp_done = 0; finishing = 0; got_err = 0;
    rd_pend = 0; rd_exp = '0; rd_seen = 0; wr_seen = 0; fin = 0;
    starve_left = (v.starve_after == 0) ? v.starve_len : 0;
    cur_delay = v.rnd ? int'($urandom_range(0, 2)) : v.delay;

    for (int guard = 0; guard < 2000; guard++) begin
      wr_valid = v.rnd ? (($urandom % 4) != 0) : (starve_left == 0);
      wr_dat   = wdat[beat & 15];
      wb_dat_i = $urandom;
      stb_e = in_bus && (!v.we || wr_valid);
      ack_r = 0; err_r = 0; rty_r = 0;
      if (stb_e && !v.no_resp && wcnt == cur_delay) begin
        ack_r = 1;
        if (beat == v.err_beat) begin err_r = !v.rty; rty_r = v.rty; end
      end
      wb_ack = ack_r; wb_err = err_r; wb_rty = rty_r;
      #1;
      if (rd_valid) rd_seen++;
      if (wr_ready) wr_seen++;
      chk({tag, ".cyc"}, wb_cyc, in_bus);
      chk({tag, ".stb"}, wb_stb, stb_e);
      chk({tag, ".done"}, done, exp_done);
      chk({tag, ".wr_ready"}, wr_ready, v.we && stb_e && ack_r && !err_r && !rty_r);
      chk({tag, ".rd_valid"}, rd_valid, rd_pend);
      if (rd_pend) chk({tag, ".rd_dat"}, rd_dat, rd_exp);
      if (in_bus) chk({tag, ".we"}, wb_we, v.we);
      if (stb_e) begin
        chk({tag, ".adr"}, wb_adr, exp_adr(v.adr, bte_e, beat));
        chk({tag, ".cti"}, wb_cti, (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010));
        chk({tag, ".sel"}, wb_sel, (n == 1) ? v.sel : 4'hf);
        chk({tag, ".bte"}, wb_bte, bte_e);
        if (v.we) chk({tag, ".wdat"}, wb_dat_o, wdat[beat & 15]);
      end
      if (exp_done) begin
        chk({tag, ".err"}, err, v.exp_err);
        chk({tag, ".beats"}, v.we ? wr_seen : rd_seen, v.exp_beats);
        fin = 1;
        break;
      end
      // reference model update for this cycle
      rd_pend = 0;
      if (stb_e && (err_r || rty_r)) begin
        in_bus = 0; got_err = 1; finishing = 1;
      end else if (stb_e && ack_r) begin
        if (!v.we) begin rd_pend = 1; rd_exp = wb_dat_i; end
        beat++; wcnt = 0; wd = 0;
        cur_delay = v.rnd ? int'($urandom_range(0, 2)) : v.delay;
        if (beat == v.starve_after) starve_left = v.starve_len;
        if (beat == n) begin in_bus = 0; finishing = 1; end
      end else if (stb_e) begin
        wcnt++; wd++;
        if (wd == TIMEOUT) begin in_bus = 0; got_err = 1; finishing = 1; end
      end else if (in_bus && starve_left > 0) begin
        starve_left--;
      end
      exp_done = finishing; finishing = 0;
      @(negedge clk);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL %s.no_done: got done=0 expected done=1 within 2000 cycles", tag);
    end
    if (got_err != v.exp_err) begin
      total++; bad++;
      $display("FAIL %s.model: got model_err=%0d expected %0d", tag, got_err, v.exp_err);
    end
    @(negedge clk);
    wb_ack = 0; wb_err = 0; wb_rty = 0; wr_valid = 0;
    #1;
    chk({tag, ".done_clear"}, done, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    //        we  adr            len    bte    sel    dly err rty sa sl nr rnd eerr ebeats
    tbl[0] = '{1'b0, 32'h0000_0100, 5'd1,  2'd0, 4'h3, 2, -1, 0, -1, 0, 0, 0, 0, 1};
    tbl[1] = '{1'b0, 32'h0000_010C, 5'd4,  2'd1, 4'hf, 0, -1, 0, -1, 0, 0, 0, 0, 4};
    tbl[2] = '{1'b1, 32'h0000_0200, 5'd8,  2'd0, 4'hf, 1, -1, 0,  2, 3, 0, 0, 0, 8};
    tbl[3] = '{1'b1, 32'h0000_0300, 5'd4,  2'd0, 4'hf, 1,  1, 0, -1, 0, 0, 0, 1, 1};
    tbl[4] = '{1'b1, 32'h0000_0040, 5'd0,  2'd2, 4'h9, 0, -1, 0, -1, 0, 0, 0, 0, 1};
    tbl[5] = '{1'b0, 32'h0000_01F8, 5'd8,  2'd2, 4'h1, 1, -1, 0, -1, 0, 0, 0, 0, 8};
    tbl[6] = '{1'b0, 32'h0000_03F0, 5'd16, 2'd3, 4'hf, 0,  5, 1, -1, 0, 0, 0, 1, 5};
    tbl[7] = '{1'b0, 32'hFFFF_FFF8, 5'd4,  2'd0, 4'hf, 0, -1, 0, -1, 0, 0, 0, 0, 4};
    tbl[8] = '{1'b0, 32'h0000_0500, 5'd2,  2'd0, 4'hf, 0, -1, 0, -1, 0, 1, 0, 1, 0};
    tbl[9] = '{1'b1, 32'h0000_07C4, 5'd16, 2'd3, 4'hf, 0, -1, 0, -1, 0, 0, 0, 0, 16};

    // power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst.cyc", wb_cyc, 0); chk("rst.stb", wb_stb, 0); chk("rst.we", wb_we, 0);
    chk("rst.done", done, 0);  chk("rst.err", err, 0);    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.adr", wb_adr, 0); chk("rst.cti", wb_cti, 0); chk("rst.bte", wb_bte, 0);
    chk("rst.sel", wb_sel, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst.ready", cmd_ready, 1);

    for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

    // asynchronous reset during beat 3 of a 16-beat read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h400; cmd_len = 5'd16;
    cmd_bte = 2'd0; cmd_sel = 4'hf;
    @(negedge clk); cmd_valid = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    @(negedge clk); wb_ack = 1'b0;
    #1;
    chk("mid.cyc_before", wb_cyc, 1);
    chk("mid.adr_before", wb_adr, 32'h408);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.cyc", wb_cyc, 0); chk("mid.stb", wb_stb, 0); chk("mid.done", done, 0);
    chk("mid.adr", wb_adr, 0); chk("mid.cti", wb_cti, 0); chk("mid.rd_valid", rd_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid.no_done", done, 0);
      chk("mid.idle_ready", cmd_ready, 1);
      @(negedge clk);
    end
    run_cmd(tbl[1], "post_rst");

    // randomized commands
    for (int i = 0; i < 25; i++) begin
      int n;
      rv.we  = $urandom;
      rv.adr = {$urandom} & 32'hFFFF_FFFC;
      rv.len = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 16));
      rv.bte = $urandom;
      rv.sel = $urandom;
      n = (rv.len == 0) ? 1 : int'(rv.len);
      rv.delay = 0; rv.rnd = 1; rv.no_resp = 0; rv.starve_after = -1; rv.starve_len = 0;
      rv.rty = $urandom;
      rv.err_beat = ($urandom % 4 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      rv.exp_err   = (rv.err_beat >= 0);
      rv.exp_beats = rv.exp_err ? rv.err_beat : n;
      run_cmd(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_b3_master.md
WB_B3_MASTER -- requirements
Module: wb_b3_master

Interface
REQ-001 Parameters SHALL be: dw, 32, data width; aw, 32, address width; timeout_cycles, 255, max cycles per beat without ack/err/rty before abort.
REQ-002 Ports SHALL be:
- wb_clk_i in 1: clock
- wb_rst_n_i in 1: reset, asynchronous, active-low
- cmd_valid_i in 1: command request
- cmd_ready_o out 1: command accepted when valid&ready
- cmd_we_i in 1: 1 write, 0 read
- cmd_adr_i in aw: byte start address, word aligned
- cmd_len_i in 5: beats, 1..16 (0 treated as 1)
- cmd_bte_i in 2: burst type extension
- cmd_sel_i in 4: byte select, single-beat only
- wr_dat_i in dw: write data
- wr_valid_i in 1: write data available
- wr_ready_o out 1: write data consumed this cycle
- rd_dat_o out dw: read data
- rd_valid_o out 1: read beat strobe, no backpressure
- done_o out 1: one-cycle pulse at command end
- err_o out 1: qualifies done_o, command failed
- wb_adr_o out aw; wb_bte_o out 2; wb_cti_o out 3; wb_cyc_o out 1; wb_dat_o out dw; wb_sel_o out 4; wb_stb_o out 1; wb_we_o out 1: Wishbone B3 initiator outputs
- wb_ack_i, wb_err_i, wb_rty_i in 1; wb_dat_i in dw: Wishbone B3 initiator inputs

Function
REQ-003 States SHALL be IDLE, BUS, END; cmd_ready_o=1 only in IDLE.
REQ-004 IDLE->BUS on cmd_valid_i&cmd_ready_o; command fields registered; beat counter loaded with len-1; wb_cyc_o asserted next cycle.
REQ-005 In BUS wb_cyc_o=1; for reads wb_stb_o=1; for writes wb_stb_o=wr_valid_i and wb_dat_o=wr_dat_i.
REQ-006 wr_ready_o SHALL equal wb_we_o&wb_stb_o&wb_ack_i (combinational); a beat completes only on wb_ack_i while wb_stb_o=1.
REQ-007 wb_cti_o: len=1 -> 3'b000 with wb_sel_o=cmd_sel_i; len>1 -> 3'b010 for all beats except last, 3'b111 on last beat, wb_sel_o=4'hf.
REQ-008 wb_bte_o SHALL hold the registered cmd_bte_i for the whole command (00 when len=1).
REQ-009 Address advances by 4 on each completed beat, same cycle the ack is sampled: bte 00 full aw-bit increment (wraps at 2^aw); 01 increments bits[3:2] only; 10 bits[4:2] only; 11 bits[5:2] only; upper bits unchanged.
REQ-010 Read beat: rd_valid_o=1 and rd_dat_o=wb_dat_i registered, one cycle after ack.
REQ-011 Completion of the last beat SHALL move BUS->END with wb_cyc_o, wb_stb_o deasserted that same edge; END pulses done_o=1 err_o=0 for one cycle then ->IDLE.
REQ-012 wb_err_i or wb_rty_i while wb_stb_o=1 SHALL abort: drop cyc/stb, remaining beats discarded, END with err_o=1; err takes priority over simultaneous ack (beat not counted, no rd_valid_o, no wr_ready_o).
REQ-013 Watchdog counter cleared on each completed beat and on entry to BUS; counts every BUS cycle with wb_stb_o=1 and no response; reaching timeout_cycles SHALL abort as REQ-012.
REQ-014 Cycles with wb_stb_o=0 (write data starvation) SHALL NOT advance the watchdog; cti/adr held.
REQ-015 Inputs other than wb_ack_i/wb_err_i/wb_rty_i SHALL be ignored outside IDLE except wr_dat_i/wr_valid_i.

Reset
REQ-016 wb_rst_n_i low SHALL immediately force IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rd_valid_o, done_o, err_o=0; wb_adr_o=0, wb_cti_o=0, wb_bte_o=0, wb_sel_o=0, counters=0; cmd_ready_o=1 after release.
REQ-017 Reset mid-burst SHALL abandon the command with no done_o pulse.

Verification
REQ-018 Single read, adr 0x100, len 1, sel 4'h3, ack after 2 cycles -> cti 000, sel 4'h3, one rd_valid_o with slave data, done_o=1 err_o=0.
REQ-019 Read len 4, bte 01, adr 0x10C -> addresses 0x10C,0x100,0x104,0x108; cti 010,010,010,111; 4 rd_valid_o pulses; cyc drops after 4th ack.
REQ-020 Write len 8 bte 00, wr_valid_i low for 3 cycles after beat 2 -> stb low those cycles, no watchdog advance, 8 wr_ready_o pulses, addresses +4 linear.
REQ-021 Write len 4, wb_err_i with ack on beat 2 -> beat 2 not counted, cyc drops, done_o=1 err_o=1, 1 wr_ready_o total.
REQ-022 Read, slave never responds, timeout_cycles=255 -> abort exactly 255 cycles after stb rises, done_o=1 err_o=1.
REQ-023 Async reset asserted mid burst (beat 3 of 16) -> cyc/stb low without clock edge, no done_o, next command starts cleanly.
